aes_round_key_store: RTL and testbench
======================================

# aes_round_key_store

Round-key buffer directly downstream of `keyexpansion` in the AES-256-CTR datapath. It captures the 15 × 128-bit round keys that `keyexpansion` streams out, one per cycle. It then serves any round key by index to the cipher round engine with one-cycle registered latency. This decouples the single key-expansion pass from the many block encryptions performed per key in CTR mode.

## Interface
Parameters:
- `NUM_RK`, 15: number of round keys stored (AES-256).
- `RK_W`, 128: round-key width in bits.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `load_start`  in  1  one-cycle pulse; a new key has been applied to `keyexpansion`, so restart the fill.
- `rk_valid`  in  1  `rk_in` carries the next round key this cycle.
- `rk_in`  in  128  round key from `keyexpansion.out_key`.
- `rd_en`  in  1  read request.
- `rd_round`  in  4  round index 0..14.
- `rd_key`  out  128  registered read data.
- `rd_valid`  out  1  `rd_key`/`rd_err` valid, one cycle after `rd_en`.
- `rd_err`  out  1  read refused: index ≥ `fill_cnt`, or index > 14.
- `keys_ready`  out  1  all 15 round keys are captured.
- `fill_cnt`  out  4  number of round keys captured, 0..15.

## Operation
- FSM states: IDLE, FILL, READY.
  - IDLE → FILL on `load_start`.
  - FILL → READY when the 15th key is written.
  - FILL or READY → FILL on `load_start`, with `fill_cnt` cleared to 0 and `keys_ready` deasserted.
- In FILL, `rk_valid` writes `rk_in` to entry `fill_cnt`, then increments `fill_cnt`.
- `rk_valid` is ignored in IDLE, in READY, and in any cycle where `load_start` is asserted (the restart takes priority).
- Reads:
  - A read is accepted in any state if `rd_round < fill_cnt`, using the `fill_cnt` value from the request cycle. This allows early rounds to start before the fill completes.
  - A rejected read gives `rd_valid`=1, `rd_err`=1, `rd_key`=0.
  - An accepted read gives `rd_valid`=1, `rd_err`=0, `rd_key`=entry[`rd_round`].
- Write and read in the same cycle to the entry being written: the read is rejected, because `fill_cnt` has not yet advanced.
- `rd_round` is 4 bits wide. Value 15 is always rejected.

## Timing
- Reset values: `rd_key`=0, `rd_valid`=0, `rd_err`=0, `keys_ready`=0, `fill_cnt`=0, state IDLE.
- Read latency: exactly 1 cycle. One read per cycle is supported, with no back-pressure.
- `rk_valid` at edge N writes entry k. `fill_cnt`=k+1 is visible after edge N, so that entry is readable from cycle N+1.
- `keys_ready` rises at the same edge that writes entry 14.
- Reset asserted mid-fill aborts the fill immediately. A read in flight at that time is dropped (`rd_valid`=0 next cycle).
- `load_start` mid-read: a read issued in the same cycle as `load_start` is evaluated against the old `fill_cnt`.

## Configuration
- `ROUND_KEY_ZEROIZE_EN` defined:
  - reset and `load_start` also clear all 15 storage entries to 0 in that same cycle;
  - no stale key material survives a key change.
- Not defined:
  - storage has no reset and retains old contents until overwritten;
  - reads remain gated by `fill_cnt`, so old keys are never returned;
  - area is smaller.

## Structure
- `aes_pkg` holds `NUM_RK`, `RK_W`, the FSM state enum, and the round-index type.
- One sub-module, `rk_regfile`: 15 × 128 storage with one write port and one synchronous read port, plus an optional zeroize input.
- Top-level logic holds the FSM, `fill_cnt`, and the read accept/reject logic.

## Test plan
- Reset, then `rd_en` with `rd_round`=0 → `rd_valid`=1, `rd_err`=1, `rd_key`=0. `keys_ready`=0, `fill_cnt`=0.
- Apply `load_start`, then 15 consecutive `rk_valid` pulses.
  - Key 0 = 642423baa95efb4362d3f2ce993c0904, key 1 = 150f258aa1fe796841d7b4429c9b5a30, remaining keys from the AES-256 expansion golden model.
  - Required: `keys_ready` rises at the 15th write edge and `fill_cnt`=15.
  - Reads of indices 0..14 return the matching keys, each one cycle after its request.
- Mid-fill read: after 3 keys, read `rd_round`=2 → key 2 with `rd_err`=0. Read `rd_round`=3 → `rd_err`=1.
- In READY, read `rd_round`=15 → `rd_err`=1. Extra `rk_valid` pulses leave entries and `fill_cnt` unchanged.
- `load_start` in READY together with `rk_valid` → `keys_ready`=0 and `fill_cnt`=0 next cycle, and no entry is written. With `ROUND_KEY_ZEROIZE_EN`, storage is checked hierarchically to be all zeros.
- Reset asserted after 7 keys → all outputs return to reset values on the next edge, and a read issued in that cycle produces no `rd_valid`.

Source files
------------

// File: rtl/aes_round_key_store_pkg.sv
// Shared types and sizes for the AES-256 round-key store.
package aes_round_key_store_pkg;

  localparam int NUM_RK = 15;
  localparam int RK_W   = 128;

  typedef logic [3:0] rk_idx_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_READY
  } rks_state_e;

  localparam rk_idx_t LAST_IDX = rk_idx_t'(NUM_RK - 1);

endpackage

// File: rtl/aes_round_key_store_if.sv
// Load/read bus between keyexpansion, the round-key store and the round engine.
interface aes_round_key_store_if;
  import aes_round_key_store_pkg::*;

  logic            load_start;
  logic            rk_valid;
  logic [RK_W-1:0] rk_in;
  logic            rd_en;
  rk_idx_t         rd_round;
  logic [RK_W-1:0] rd_key;
  logic            rd_valid;
  logic            rd_err;
  logic            keys_ready;
  rk_idx_t         fill_cnt;

  modport master (
    output load_start, rk_valid, rk_in, rd_en, rd_round,
    input  rd_key, rd_valid, rd_err, keys_ready, fill_cnt
  );

  modport slave (
    input  load_start, rk_valid, rk_in, rd_en, rd_round,
    output rd_key, rd_valid, rd_err, keys_ready, fill_cnt
  );

endinterface

// File: rtl/aes_round_key_store_rk_regfile.sv
// 15 x 128 round-key storage, one write port and one registered read port.
// ROUND_KEY_ZEROIZE_EN adds a zeroize input that clears every entry.
module aes_round_key_store_rk_regfile
  import aes_round_key_store_pkg::*;
(
  input  logic            clk,
`ifdef ROUND_KEY_ZEROIZE_EN
  input  logic            i_zeroize,
`endif
  input  logic            i_we,
  input  rk_idx_t         i_waddr,
  input  logic [RK_W-1:0] i_wdata,
  input  logic            i_re,
  input  rk_idx_t         i_raddr,
  output logic [RK_W-1:0] o_rdata
);

  logic [RK_W-1:0] r_mem [NUM_RK];
  logic [RK_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
`ifdef ROUND_KEY_ZEROIZE_EN
    if (i_zeroize) begin
      for (int i = 0; i < NUM_RK; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
`else
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
`endif
  end

  // Read data is only consumed when the top accepted the read, so no reset needed.
  always_ff @(posedge clk) begin
    if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/aes_round_key_store.sv
// Round-key buffer fed by keyexpansion, served by index to the round engine.
// Optional ROUND_KEY_ZEROIZE_EN clears storage on reset and on load_start.
module aes_round_key_store
  import aes_round_key_store_pkg::*;
(
  input  logic clk,
  input  logic rst,
  aes_round_key_store_if.slave bus
);

  rks_state_e      r_state;
  rks_state_e      w_nextState;
  rk_idx_t         r_fillCnt;
  logic            r_rdValid;
  logic            r_rdOk;
  logic            w_wrEn;
  logic            w_rdAccept;
  logic [RK_W-1:0] w_rdata;

  // A restart always wins over a write arriving in the same cycle.
  assign w_wrEn     = (r_state == ST_FILL) && bus.rk_valid && !bus.load_start;
  assign w_rdAccept = bus.rd_round < r_fillCnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    if (bus.load_start) begin
      w_nextState = ST_FILL;
    end else if (w_wrEn && (r_fillCnt == LAST_IDX)) begin
      w_nextState = ST_READY;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_fillCnt <= '0;
    end else if (bus.load_start) begin
      r_fillCnt <= '0;
    end else if (w_wrEn) begin
      r_fillCnt <= r_fillCnt + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rdValid <= 1'b0;
      r_rdOk    <= 1'b0;
    end else begin
      r_rdValid <= bus.rd_en;
      r_rdOk    <= bus.rd_en && w_rdAccept;
    end
  end

  always_comb begin
    bus.keys_ready = (r_state == ST_READY);
    bus.fill_cnt   = r_fillCnt;
    bus.rd_valid   = r_rdValid;
    bus.rd_err     = r_rdValid && !r_rdOk;
    bus.rd_key     = r_rdOk ? w_rdata : '0;
  end

  aes_round_key_store_rk_regfile u_regfile (
    .clk       (clk),
`ifdef ROUND_KEY_ZEROIZE_EN
    .i_zeroize (!rst || bus.load_start),
`endif
    .i_we      (w_wrEn),
    .i_waddr   (r_fillCnt),
    .i_wdata   (bus.rk_in),
    .i_re      (bus.rd_en && w_rdAccept),
    .i_raddr   (bus.rd_round),
    .o_rdata   (w_rdata)
  );

endmodule

// File: tb/tb_aes_round_key_store.sv
// Directed bench for aes_round_key_store; expected keys come from an AES-256 key-expansion model.
// With ROUND_KEY_ZEROIZE_EN defined the storage is also inspected for zeroization.
module tb_aes_round_key_store;
  import aes_round_key_store_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   nChecks = 0;
  int   nFails  = 0;

  logic [127:0] rk [15];
  logic [31:0]  w  [60];

  typedef struct {
    logic [3:0]   rdRound;
    logic         expErr;
    logic [127:0] expKey;
  } rdVec_t;

  rdVec_t rdVecs [16];

  aes_round_key_store_if bus ();

  aes_round_key_store dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // GF(2^8) multiply used both for the S-box inverse and for Rcon doubling.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    logic [7:0] r;
    r = x;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] inv;
    inv = 8'h01;
    for (int i = 0; i < 254; i++) inv = gmul(inv, x);
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [31:0] subWord(input logic [31:0] x);
    return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
  endfunction

  // AES-256 expansion of the 256-bit key formed by round keys 0 and 1.
  task automatic computeKeys();
    logic [127:0] k0;
    logic [127:0] k1;
    logic [31:0]  temp;
    logic [7:0]   rc;
    k0 = 128'h642423baa95efb4362d3f2ce993c0904;
    k1 = 128'h150f258aa1fe796841d7b4429c9b5a30;
    for (int i = 0; i < 4; i++) begin
      w[i]     = k0[127 - 32*i -: 32];
      w[i + 4] = k1[127 - 32*i -: 32];
    end
    rc = 8'h01;
    for (int i = 8; i < 60; i++) begin
      temp = w[i - 1];
      if (i % 8 == 0) begin
        temp = subWord({temp[23:0], temp[31:24]}) ^ {rc, 24'h000000};
        rc   = gmul(rc, 8'h02);
      end else if (i % 8 == 4) begin
        temp = subWord(temp);
      end
      w[i] = w[i - 8] ^ temp;
    end
    for (int r = 0; r < 15; r++) begin
      rk[r] = {w[4*r], w[4*r + 1], w[4*r + 2], w[4*r + 3]};
    end
  endtask

  task automatic checkOutput(input string name, input logic [127:0] actual,
                             input logic [127:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic checkBit(input string name, input logic actual, input logic expected);
    checkOutput(name, 128'(actual), 128'(expected));
  endtask

  task automatic checkCnt(input string name, input logic [3:0] actual, input logic [3:0] expected);
    checkOutput(name, 128'(actual), 128'(expected));
  endtask

  // Drive one cycle of inputs, step past the rising edge, then drop the pulses.
  task automatic applyStimulus(input logic ld, input logic rkv, input logic [127:0] rkIn,
                               input logic rdEn, input logic [3:0] rdRound);
    bus.load_start = ld;
    bus.rk_valid   = rkv;
    bus.rk_in      = rkIn;
    bus.rd_en      = rdEn;
    bus.rd_round   = rdRound;
    @(posedge clk);
    #1;
    bus.load_start = 1'b0;
    bus.rk_valid   = 1'b0;
    bus.rd_en      = 1'b0;
  endtask

  task automatic checkRead(input string name, input logic expErr, input logic [127:0] expKey);
    checkBit({name, " rd_valid"}, bus.rd_valid, 1'b1);
    checkBit({name, " rd_err"}, bus.rd_err, expErr);
    checkOutput({name, " rd_key"}, bus.rd_key, expKey);
  endtask

`ifdef ROUND_KEY_ZEROIZE_EN
  task automatic checkZeroized(input string name);
    for (int i = 0; i < NUM_RK; i++) begin
      checkOutput($sformatf("%s entry%0d", name, i), dut.u_regfile.r_mem[i], 128'h0);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not reach the summary");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    computeKeys();
    for (int i = 0; i < 16; i++) begin
      rdVecs[i].rdRound = 4'(i);
      rdVecs[i].expErr  = (i == 15);
      rdVecs[i].expKey  = 128'h0;
      if (i < 15) rdVecs[i].expKey = rk[i];
    end

    bus.load_start = 1'b0;
    bus.rk_valid   = 1'b0;
    bus.rk_in      = '0;
    bus.rd_en      = 1'b0;
    bus.rd_round   = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    checkBit("reset rd_valid", bus.rd_valid, 1'b0);
    checkBit("reset keys_ready", bus.keys_ready, 1'b0);
    checkCnt("reset fill_cnt", bus.fill_cnt, 4'd0);
    checkOutput("reset rd_key", bus.rd_key, 128'h0);

    // IDLE read is refused and rk_valid is ignored
    applyStimulus(1'b0, 1'b1, rk[0], 1'b1, 4'd0);
    checkRead("idle read0", 1'b1, 128'h0);
    checkCnt("idle fill_cnt", bus.fill_cnt, 4'd0);
    checkBit("idle keys_ready", bus.keys_ready, 1'b0);

    applyStimulus(1'b1, 1'b0, '0, 1'b0, 4'd0);
    checkCnt("load fill_cnt", bus.fill_cnt, 4'd0);

    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 1'b1, rk[k], 1'b0, 4'd0);
      checkCnt($sformatf("fill%0d fill_cnt", k), bus.fill_cnt, 4'(k + 1));
    end

    // Mid-fill reads, including a read of the entry being written
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 4'd2);
    checkRead("midfill read2", 1'b0, rk[2]);
    applyStimulus(1'b0, 1'b1, rk[3], 1'b1, 4'd3);
    checkRead("write-read3", 1'b1, 128'h0);
    checkCnt("write-read3 fill_cnt", bus.fill_cnt, 4'd4);
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 4'd3);
    checkRead("midfill read3", 1'b0, rk[3]);

    for (int k = 4; k < 15; k++) begin
      applyStimulus(1'b0, 1'b1, rk[k], 1'b0, 4'd0);
      if (k >= 13) begin
        checkBit($sformatf("fill%0d keys_ready", k), bus.keys_ready, k == 14);
        checkCnt($sformatf("fill%0d fill_cnt", k), bus.fill_cnt, 4'(k + 1));
      end
    end

    // Back-to-back reads of every index in READY
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b0, 1'b0, '0, 1'b1, rdVecs[i].rdRound);
      checkRead($sformatf("ready read%0d", i), rdVecs[i].expErr, rdVecs[i].expKey);
    end

    // Extra rk_valid in READY changes nothing
    repeat (2) applyStimulus(1'b0, 1'b1, {128{1'b1}}, 1'b0, 4'd0);
    checkCnt("extra fill_cnt", bus.fill_cnt, 4'd15);
    checkBit("extra keys_ready", bus.keys_ready, 1'b1);
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 4'd14);
    checkRead("extra read14", 1'b0, rk[14]);

    // Restart with a simultaneous write and a read against the old fill count
    applyStimulus(1'b1, 1'b1, {128{1'b1}}, 1'b1, 4'd5);
    checkRead("restart read5", 1'b0, rk[5]);
    checkBit("restart keys_ready", bus.keys_ready, 1'b0);
    checkCnt("restart fill_cnt", bus.fill_cnt, 4'd0);
`ifdef ROUND_KEY_ZEROIZE_EN
    checkZeroized("restart");
`endif
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 4'd0);
    checkRead("restart read0", 1'b1, 128'h0);
    checkCnt("restart2 fill_cnt", bus.fill_cnt, 4'd0);

    // Refill 7 keys in reverse order, then reset with a read in flight
    for (int k = 0; k < 7; k++) begin
      applyStimulus(1'b0, 1'b1, rk[14 - k], 1'b0, 4'd0);
    end
    checkCnt("refill fill_cnt", bus.fill_cnt, 4'd7);
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 4'd6);
    checkRead("refill read6", 1'b0, rk[8]);

    rst = 1'b0;
    applyStimulus(1'b0, 1'b1, rk[0], 1'b1, 4'd3);
    checkBit("abort rd_valid", bus.rd_valid, 1'b0);
    checkBit("abort rd_err", bus.rd_err, 1'b0);
    checkOutput("abort rd_key", bus.rd_key, 128'h0);
    checkCnt("abort fill_cnt", bus.fill_cnt, 4'd0);
    checkBit("abort keys_ready", bus.keys_ready, 1'b0);
`ifdef ROUND_KEY_ZEROIZE_EN
    checkZeroized("abort");
`endif
    rst = 1'b1;
    applyStimulus(1'b0, 1'b1, rk[0], 1'b1, 4'd0);
    checkRead("post-abort read0", 1'b1, 128'h0);
    checkCnt("post-abort fill_cnt", bus.fill_cnt, 4'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
